// File: rtl/song_sequencer.sv
// song_sequencer
// Frame-rate song-position controller. Divides new_frame pulses into steps
// and steps into patterns, fetches each pattern's order-list entry from an
// external order ROM over a req/ack handshake, and prefetches the following
// entry while the current pattern plays.

module song_sequencer #(
  parameter int SONG_LEN        = 12,
  parameter int LOOP_POS        = 4,
  parameter int POS_BITS        = 4,
  parameter int STEP_BITS       = 4,
  parameter int FRAMES_PER_STEP = 6,
  parameter int FDIV_BITS       = 3,
  parameter int ENTRY_BITS      = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  new_frame,
  input  logic                  run,
  output logic                  order_req,
  output logic [POS_BITS-1:0]   order_addr,
  input  logic                  order_ack,
  input  logic [ENTRY_BITS-1:0] order_data,
  output logic [ENTRY_BITS-1:0] entry,
  output logic [POS_BITS-1:0]   song_pos,
  output logic [STEP_BITS-1:0]  step,
  output logic                  step_strobe,
  output logic                  looped,
  output logic                  underrun
);

  localparam logic [POS_BITS-1:0]  LAST_POS  = POS_BITS'(SONG_LEN - 1);
  localparam logic [POS_BITS-1:0]  WRAP_POS  = POS_BITS'(LOOP_POS);
  localparam logic [FDIV_BITS-1:0] FDIV_LAST = FDIV_BITS'(FRAMES_PER_STEP - 1);
  localparam logic [STEP_BITS-1:0] STEP_LAST = '1;

  typedef enum logic [1:0] {
    S_START = 2'd0,
    S_FIRST = 2'd1,
    S_PLAY  = 2'd2,
    S_WAIT  = 2'd3
  } state_t;

  state_t                state_q;
  logic                  orderReq_q;
  logic [POS_BITS-1:0]   orderAddr_q;
  logic [ENTRY_BITS-1:0] entry_q;
  logic [POS_BITS-1:0]   songPos_q;
  logic [STEP_BITS-1:0]  step_q;
  logic                  stepStrobe_q;
  logic                  looped_q;
  logic                  underrun_q;
  logic [FDIV_BITS-1:0]  fdiv_q;
  logic [ENTRY_BITS-1:0] staged_q;
  logic                  stagedValid_q;

  logic [POS_BITS-1:0]   nextPos_d;
  logic                  ackValid;
  logic                  frameTick;

  // Position that follows the current one, wrapping to the loop point at the end.
  always_comb begin
    nextPos_d = (songPos_q == LAST_POS) ? WRAP_POS : songPos_q + POS_BITS'(1);
    ackValid  = order_ack && orderReq_q;
    frameTick = new_frame && run;
  end

  // Sequencer FSM: fetch handshake, frame/step counting and pattern advance.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= S_START;
      orderReq_q    <= 1'b0;
      orderAddr_q   <= '0;
      entry_q       <= '0;
      songPos_q     <= '0;
      step_q        <= '0;
      stepStrobe_q  <= 1'b0;
      looped_q      <= 1'b0;
      underrun_q    <= 1'b0;
      fdiv_q        <= '0;
      staged_q      <= '0;
      stagedValid_q <= 1'b0;
    end else begin
      stepStrobe_q <= 1'b0;
      case (state_q)
        S_START: begin
          orderReq_q  <= 1'b1;
          orderAddr_q <= '0;
          state_q     <= S_FIRST;
        end

        S_FIRST: begin
          if (ackValid) begin
            entry_q      <= order_data;
            songPos_q    <= '0;
            step_q       <= '0;
            fdiv_q       <= '0;
            orderReq_q   <= 1'b0;
            stepStrobe_q <= 1'b1;
            state_q      <= S_PLAY;
          end
        end

        S_PLAY: begin
          // Prefetch is issued whenever nothing is staged or outstanding.
          if (!stagedValid_q && !orderReq_q) begin
            orderReq_q  <= 1'b1;
            orderAddr_q <= nextPos_d;
          end
          if (ackValid) begin
            staged_q      <= order_data;
            stagedValid_q <= 1'b1;
            orderReq_q    <= 1'b0;
          end
          if (frameTick) begin
            if (fdiv_q < FDIV_LAST) begin
              fdiv_q <= fdiv_q + FDIV_BITS'(1);
            end else begin
              fdiv_q <= '0;
              if (step_q != STEP_LAST) begin
                step_q       <= step_q + STEP_BITS'(1);
                stepStrobe_q <= 1'b1;
              end else if (stagedValid_q) begin
                entry_q       <= staged_q;
                songPos_q     <= nextPos_d;
                step_q        <= '0;
                stagedValid_q <= 1'b0;
                stepStrobe_q  <= 1'b1;
                if (songPos_q == LAST_POS) looped_q <= 1'b1;
              end else if (ackValid) begin
                // Data arriving exactly at the boundary goes straight to entry.
                entry_q       <= order_data;
                songPos_q     <= nextPos_d;
                step_q        <= '0;
                stagedValid_q <= 1'b0;
                orderReq_q    <= 1'b0;
                stepStrobe_q  <= 1'b1;
                if (songPos_q == LAST_POS) looped_q <= 1'b1;
              end else begin
                // Pattern ended with the fetch still pending: stall on the last step.
                underrun_q <= 1'b1;
                state_q    <= S_WAIT;
              end
            end
          end
        end

        S_WAIT: begin
          fdiv_q <= '0;
          if (ackValid) begin
            entry_q      <= order_data;
            songPos_q    <= nextPos_d;
            step_q       <= '0;
            orderReq_q   <= 1'b0;
            stepStrobe_q <= 1'b1;
            if (songPos_q == LAST_POS) looped_q <= 1'b1;
            state_q      <= S_PLAY;
          end
        end

        default: state_q <= S_START;
      endcase
    end
  end

  assign order_req   = orderReq_q;
  assign order_addr  = orderAddr_q;
  assign entry       = entry_q;
  assign song_pos    = songPos_q;
  assign step        = step_q;
  assign step_strobe = stepStrobe_q;
  assign looped      = looped_q;
  assign underrun    = underrun_q;

endmodule

// File: tb/tb_song_sequencer.sv
// tb_song_sequencer
// Randomized bench for song_sequencer. A responder plays the order ROM with
// random latency; a reference model tracks the song as frames-into-pattern,
// a staging queue and a song position, and every output is compared each cycle.

module tb_song_sequencer;

  localparam int SONG_LEN        = 12;
  localparam int LOOP_POS        = 4;
  localparam int POS_BITS        = 4;
  localparam int STEP_BITS       = 4;
  localparam int FRAMES_PER_STEP = 6;
  localparam int FDIV_BITS       = 3;
  localparam int ENTRY_BITS      = 8;
  localparam int PATTERN_FRAMES  = (1 << STEP_BITS) * FRAMES_PER_STEP;
  localparam int NUM_CYCLES      = 12000;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  new_frame;
  logic                  run;
  logic                  order_req;
  logic [POS_BITS-1:0]   order_addr;
  logic                  order_ack;
  logic [ENTRY_BITS-1:0] order_data;
  logic [ENTRY_BITS-1:0] entry;
  logic [POS_BITS-1:0]   song_pos;
  logic [STEP_BITS-1:0]  step;
  logic                  step_strobe;
  logic                  looped;
  logic                  underrun;

  always #5 clk = ~clk;

  song_sequencer #(
    .SONG_LEN(SONG_LEN), .LOOP_POS(LOOP_POS), .POS_BITS(POS_BITS),
    .STEP_BITS(STEP_BITS), .FRAMES_PER_STEP(FRAMES_PER_STEP),
    .FDIV_BITS(FDIV_BITS), .ENTRY_BITS(ENTRY_BITS)
  ) dut (
    .clk(clk), .reset(reset), .new_frame(new_frame), .run(run),
    .order_req(order_req), .order_addr(order_addr), .order_ack(order_ack),
    .order_data(order_data), .entry(entry), .song_pos(song_pos), .step(step),
    .step_strobe(step_strobe), .looped(looped), .underrun(underrun)
  );

  logic [ENTRY_BITS-1:0] rom [SONG_LEN];

  // Reference model: phase 0 after reset, 1 fetching first entry, 2 playing, 3 stalled.
  int mPhase;
  bit mReq;
  int mAddr;
  int mEntry;
  int mPos;
  int mFrames;
  bit mStrobe;
  bit mLooped;
  bit mUnderrun;
  int mStaged[$];

  int checks = 0;
  int errors = 0;
  int bypassCount = 0;
  int underrunCount = 0;
  int loopCount = 0;

  // Compare one observed value against the model and count the result.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic int nextPosOf(input int p);
    return (p == SONG_LEN - 1) ? LOOP_POS : p + 1;
  endfunction

  task automatic advanceTo(input int data);
    if (mPos == SONG_LEN - 1) begin
      mLooped = 1'b1;
      loopCount++;
    end
    mPos    = nextPosOf(mPos);
    mEntry  = data;
    mFrames = 0;
    mStrobe = 1'b1;
  endtask

  // Advance the model by one clock given the inputs presented in that cycle.
  task automatic modelStep(input bit rstn, input bit nf, input bit rn, input bit ack, input int data);
    bit ackOk;
    bit startReq;
    int oldPos;
    if (!rstn) begin
      mPhase = 0; mReq = 0; mAddr = 0; mEntry = 0; mPos = 0; mFrames = 0;
      mStrobe = 0; mLooped = 0; mUnderrun = 0;
      mStaged.delete();
      return;
    end
    mStrobe = 1'b0;
    ackOk   = ack && mReq;
    oldPos  = mPos;
    case (mPhase)
      0: begin
        mPhase = 1; mReq = 1; mAddr = 0;
      end
      1: begin
        if (ackOk) begin
          mEntry = data; mPos = 0; mFrames = 0; mReq = 0; mStrobe = 1; mPhase = 2;
        end
      end
      2: begin
        startReq = (mStaged.size() == 0) && !mReq;
        if (nf && rn) begin
          mFrames++;
          if (mFrames % FRAMES_PER_STEP == 0) begin
            if (mFrames < PATTERN_FRAMES) begin
              mStrobe = 1'b1;
            end else if (mStaged.size() != 0) begin
              advanceTo(mStaged.pop_front());
            end else if (ackOk) begin
              advanceTo(data);
              ackOk = 1'b0;
              mReq  = 1'b0;
              bypassCount++;
            end else begin
              mUnderrun = 1'b1;
              mPhase    = 3;
              mFrames   = PATTERN_FRAMES - FRAMES_PER_STEP;
              underrunCount++;
            end
          end
        end
        if (ackOk) begin
          mStaged.push_back(data);
          mReq = 1'b0;
        end
        if (startReq) begin
          mReq  = 1'b1;
          mAddr = nextPosOf(oldPos);
        end
      end
      default: begin
        if (ackOk) begin
          advanceTo(data);
          mReq   = 1'b0;
          mPhase = 2;
        end
      end
    endcase
  endtask

  // Drive one cycle of inputs, step the model, then compare after the edge.
  task automatic applyStimulus(input bit rstn, input bit nf, input bit rn, input bit ack, input logic [ENTRY_BITS-1:0] data);
    reset      = rstn;
    new_frame  = nf;
    run        = rn;
    order_ack  = ack;
    order_data = data;
    modelStep(rstn, nf, rn, ack, int'(data));
    @(posedge clk);
    @(negedge clk);
    checkOutput("order_req",   32'(order_req),   32'(mReq));
    checkOutput("order_addr",  32'(order_addr),  32'(mAddr));
    checkOutput("entry",       32'(entry),       32'(mEntry));
    checkOutput("song_pos",    32'(song_pos),    32'(mPos));
    checkOutput("step",        32'(step),        32'(mFrames / FRAMES_PER_STEP));
    checkOutput("step_strobe", 32'(step_strobe), 32'(mStrobe));
    checkOutput("looped",      32'(looped),      32'(mLooped));
    checkOutput("underrun",    32'(underrun),    32'(mUnderrun));
  endtask

  function automatic int pickLatency();
    int r;
    r = $urandom_range(0, 99);
    if (r < 60) return $urandom_range(0, 3);
    if (r < 85) return $urandom_range(4, 40);
    return $urandom_range(150, 260);
  endfunction

  initial begin
    bit prevReq;
    int latency;
    int runHold;
    int resetHold;
    bit nf;
    bit rn;
    bit ack;
    bit rstn;
    logic [ENTRY_BITS-1:0] data;

    for (int i = 0; i < SONG_LEN; i++) rom[i] = ENTRY_BITS'($urandom);
    modelStep(1'b0, 1'b0, 1'b0, 1'b0, 0);

    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);

    prevReq   = 1'b0;
    latency   = 0;
    runHold   = 0;
    resetHold = 0;

    for (int cyc = 0; cyc < NUM_CYCLES; cyc++) begin
      if (cyc == 6000 || cyc == 9000) resetHold = $urandom_range(1, 3);
      rstn = (resetHold == 0);
      if (resetHold > 0) resetHold--;

      if (runHold == 0 && $urandom_range(0, 199) == 0) runHold = $urandom_range(20, 60);
      rn = (runHold == 0);
      if (runHold > 0) runHold--;
      nf = ($urandom_range(0, 1) == 1);

      ack  = 1'b0;
      data = ENTRY_BITS'($urandom);
      if (mReq) begin
        if (!prevReq) latency = pickLatency();
        if (latency == 0) begin
          ack  = 1'b1;
          data = rom[mAddr];
        end else begin
          latency--;
        end
        if (mPhase == 2 && mFrames == PATTERN_FRAMES - 1 && latency > 0 && $urandom_range(0, 1) == 1) begin
          nf   = 1'b1;
          rn   = 1'b1;
          ack  = 1'b1;
          data = rom[mAddr];
        end
      end else if ($urandom_range(0, 19) == 0) begin
        ack = 1'b1;
      end
      prevReq = mReq && !ack && rstn;

      applyStimulus(rstn, nf, rn, ack, data);
    end

    $display("[TB] coverage: %0d bypass advances, %0d underruns, %0d loop-backs",
             bypassCount, underrunCount, loopCount);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/song_sequencer.md
Name: song_sequencer

Overview:
- Frame-rate song-position controller for the demo synth.
- Counts new_frame pulses into steps and steps into patterns.
- Fetches each pattern's order-list entry from an external order ROM over a req/ack handshake, and prefetches the next entry while the current pattern plays.
- Presents the current entry and step to the player/graphics side; flags late fetches (underrun) and song loop-back.

Parameters:
SONG_LEN, 12, number of order-list entries (positions 0..SONG_LEN-1)
LOOP_POS, 4, position the song returns to after position SONG_LEN-1
POS_BITS, 4, width of song position / order address
STEP_BITS, 4, step counter width; pattern length is 2**STEP_BITS steps
FRAMES_PER_STEP, 6, new_frame pulses per step (must be >=1)
FDIV_BITS, 3, frame divider width (holds values up to FRAMES_PER_STEP-1)
ENTRY_BITS, 8, order-list entry width

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset (0 at a clk edge resets the block)
new_frame  in  1  one-cycle pulse per video frame
run  in  1  level; 0 freezes frame/step counting
order_req  out  1  fetch request; held until ack
order_addr  out  POS_BITS  position being fetched; stable while order_req=1
order_ack  in  1  one-cycle ack; order_data valid in the same cycle
order_data  in  ENTRY_BITS  fetched entry
entry  out  ENTRY_BITS  current pattern entry (player control source)
song_pos  out  POS_BITS  position of the current entry
step  out  STEP_BITS  current step within the pattern
step_strobe  out  1  one-cycle pulse when step/entry take new values
looped  out  1  sticky; set on the first wrap from SONG_LEN-1 to LOOP_POS
underrun  out  1  sticky; set when a pattern ends before its prefetch completed

Behaviour:
- All outputs are registered. On reset the block enters START with every output 0: order_req, order_addr, entry, song_pos, step, step_strobe, looped, underrun. The internal frame divider (fdiv) and staged_valid are also 0.
- next_pos = (song_pos==SONG_LEN-1) ? LOOP_POS : song_pos+1.
- START: the cycle after reset deasserts, go to FIRST with order_req=1 and order_addr=0.
- FIRST:
  - Wait for order_ack.
  - On ack: entry<=order_data, song_pos<=0, step<=0, fdiv<=0, order_req<=0; step_strobe=1 in the next cycle; go to PLAY.
- PLAY, prefetch:
  - If !staged_valid and !order_req, assert order_req the next cycle with order_addr=next_pos.
  - On ack: staged<=order_data, staged_valid<=1, order_req<=0.
- PLAY, frame tick: a frame tick is new_frame&&run. On a tick with fdiv<FRAMES_PER_STEP-1, fdiv increments. Otherwise the tick is a step boundary and fdiv<=0.
- PLAY, step boundary, step<2**STEP_BITS-1: step increments; strobe.
- PLAY, step boundary, last step, staged_valid=1: entry<=staged, song_pos<=next_pos, step<=0, staged_valid<=0; strobe; looped<=1 if song_pos was SONG_LEN-1. The next prefetch request rises the following cycle.
- PLAY, step boundary, last step, ack in the same cycle: bypass. Treat it as the staged_valid=1 case using order_data, clear order_req, and do not set staged_valid.
- PLAY, step boundary, last step, no data: underrun<=1 and go to WAIT. step holds at the last step, there is no strobe, and order_req stays asserted.
- WAIT:
  - new_frame is ignored and fdiv is held at 0.
  - On ack: entry<=order_data, song_pos<=next_pos, step<=0, order_req<=0; strobe; update looped as above; go to PLAY.
- step_strobe is high for exactly one cycle per update and is never high in consecutive cycles.
- Ignored inputs:
  - order_ack while order_req=0.
  - new_frame while run=0; fdiv and step are held.
  - run has no effect on an outstanding fetch.
- Reset asserted mid-fetch or mid-WAIT: order_req is 0 after that edge, and an ack arriving during or after reset is discarded. The sticky flags are cleared only by reset.
- Arithmetic is unsigned and modular within each field. song_pos never exceeds SONG_LEN-1.

Test Plan:
- Reset held 3 cycles, then released; ack 3 cycles after order_req rises with data 0xA5 -> all outputs 0 during reset; order_addr=0; entry=0xA5, step=0 and step_strobe pulse one cycle after the ack; prefetch of order_addr=1 starts the next cycle.
- run=1, 12 new_frame pulses, prefetch acked immediately -> strobes after frames 6 and 12; step=1 then 2; fdiv resets each time.
- Run through song_pos=11 with prompt acks -> after step 15 of position 11, order_addr=4, song_pos=4, looped=1, underrun=0.
- Withhold ack past step 15's boundary, then ack 5 cycles later with 0x3C -> underrun=1, no strobe at the boundary, step stays 15; on the ack entry=0x3C, step=0, one strobe.
- order_ack coincident with the last-step boundary -> entry takes order_data that cycle (bypass), no underrun, exactly one strobe.
- run=0 for 20 new_frame pulses mid-pattern, plus a stray ack with order_req=0 -> step, fdiv, entry and staged state unchanged; counting resumes at the held fdiv when run=1.
